// File: rtl/boot_loader_ctrl.sv
// Boot controller: holds the core in reset while a framed program image arrives
// byte by byte from the UART. Bytes are packed little-endian into 32-bit words and
// written to instruction memory. When the image is complete the core is released
// to run from PC 0. A reload request in RUN stops the core and waits for a new image.
module boot_loader_ctrl #(
    parameter int         IMEM_ADDR_W = 10,
    parameter logic [7:0] SYNC_BYTE   = 8'h55
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   reload,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   core_rst,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            words_loaded
);

    localparam logic [2:0] S_SYNC   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    // Largest image the memory can hold, one bit wider than len so 2**16 cannot wrap.
    localparam logic [16:0] MAX_WORDS = 17'(1) << IMEM_ADDR_W;

    logic [2:0]  state;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;   // first three bytes of the word being assembled
    logic [15:0] len_full;   // length as it will be once LEN_HI is captured

    assign len_full = {rx_data, len[7:0]};

    // Frame parser, word packer and core reset sequencing; every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_SYNC;
            core_rst     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (rx_valid && rx_data == SYNC_BYTE) state <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (rx_valid) begin
                        len[7:0] <= rx_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        len[15:8] <= rx_data;
                        if (len_full == 16'd0) begin
                            // Empty image: release the core straight away.
                            state    <= S_RUN;
                            core_rst <= 1'b0;
                            done     <= 1'b1;
                        end else if ({1'b0, len_full} > MAX_WORDS) begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end else begin
                            state        <= S_DATA;
                            byte_idx     <= '0;
                            words_loaded <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_wdata   <= {rx_data, word_buf};
                                imem_addr    <= words_loaded[IMEM_ADDR_W-1:0];
                                words_loaded <= words_loaded + 16'd1;
                                if (words_loaded + 16'd1 == len) state <= S_DRAIN;
                            end
                        endcase
                    end
                end
                S_DRAIN: begin
                    // One idle cycle so the final write lands before the core starts.
                    state    <= S_RUN;
                    core_rst <= 1'b0;
                    done     <= 1'b1;
                end
                S_RUN: begin
                    // Reload takes priority; any byte arriving with it is dropped.
                    if (reload) begin
                        state        <= S_SYNC;
                        core_rst     <= 1'b1;
                        done         <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                    end
                end
                S_ERROR: begin
                    // Sticky until rst.
                    err      <= 1'b1;
                    core_rst <= 1'b1;
                end
                default: state <= S_SYNC;
            endcase
        end
    end

endmodule
